// File: rtl/pe_pkg.sv
// Shared definitions for the pe_* arbiter family: mode encodings, FSM state type
// and a constant-evaluable clog2 used to size index ports.
package pe_pkg;

    localparam logic PE_MODE_FIXED = 1'b0;
    localparam logic PE_MODE_RR    = 1'b1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } pe_state_t;

    // Smallest r with 2**r >= value; returns 1 for value <= 2 so ports never collapse to zero width.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pe_rot_scan.sv
// Combinational priority scan: starting at 'start' and moving downward (wrapping
// from 0 to N-1), the first set bit of req wins.
module pe_rot_scan
    import pe_pkg::*;
#(
    parameter  int N    = 8,
    localparam int IDXW = clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] start,
    output logic [N-1:0]    win,
    output logic [IDXW-1:0] idx,
    output logic            found
);

    always_comb begin
        int              j;
        logic [IDXW-1:0] jj;
        win   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        jj    = '0;
        for (int k = 0; k < N; k++) begin
            j = int'(start) - k;
            if (j < 0) begin
                j = j + N;
            end
            jj = IDXW'(j);
            if (!found && req[jj]) begin
                found   = 1'b1;
                win[jj] = 1'b1;
                idx     = jj;
            end
        end
    end

endmodule

// File: rtl/pe_arb_rr.sv
// Registered N-way arbiter, fixed priority (MSB highest) or round-robin, that
// holds each grant until ack and re-arbitrates on ack with no bubble.
module pe_arb_rr
    import pe_pkg::*;
#(
    parameter  int N    = 8,
    localparam int IDXW = clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic            mode,
    input  logic            ack,
    output logic [N-1:0]    gnt,
    output logic [IDXW-1:0] gnt_idx,
    output logic            gnt_valid,
    output logic            busy_none
);

    // Handshake: a grant is offered while gnt_valid=1 and is retired on any cycle
    // with ack=1; ack while gnt_valid=0 is ignored.

    pe_state_t       state, state_nxt;
    logic [IDXW-1:0] ptr, ptr_nxt;
    logic [IDXW-1:0] arb_ptr;
    logic [IDXW-1:0] scan_start;
    logic [N-1:0]    scan_win;
    logic [IDXW-1:0] scan_idx;
    logic            scan_found;
    logic [N-1:0]    gnt_nxt;
    logic [IDXW-1:0] idx_nxt;
    logic            valid_nxt;
    logic            busy_nxt;

    // The pointer moves past the retiring winner before the same-cycle re-arbitration.
    assign arb_ptr = (state == ST_GRANT && ack && mode == PE_MODE_RR)
                   ? ((gnt_idx == '0) ? IDXW'(N - 1) : gnt_idx - IDXW'(1))
                   : ptr;

    assign scan_start = (mode == PE_MODE_RR) ? arb_ptr : IDXW'(N - 1);

    pe_rot_scan #(.N(N)) u_scan (
        .req   (req),
        .start (scan_start),
        .win   (scan_win),
        .idx   (scan_idx),
        .found (scan_found)
    );

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        gnt_nxt   = gnt;
        idx_nxt   = gnt_idx;
        valid_nxt = gnt_valid;
        case (state)
            ST_IDLE: begin
                if (scan_found) begin
                    state_nxt = ST_GRANT;
                    gnt_nxt   = scan_win;
                    idx_nxt   = scan_idx;
                    valid_nxt = 1'b1;
                end else begin
                    gnt_nxt   = '0;
                    idx_nxt   = '0;
                    valid_nxt = 1'b0;
                end
            end
            ST_GRANT: begin
                if (ack) begin
                    ptr_nxt = arb_ptr;
                    if (scan_found) begin
                        gnt_nxt = scan_win;
                        idx_nxt = scan_idx;
                    end else begin
                        state_nxt = ST_IDLE;
                        gnt_nxt   = '0;
                        idx_nxt   = '0;
                        valid_nxt = 1'b0;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                gnt_nxt   = '0;
                idx_nxt   = '0;
                valid_nxt = 1'b0;
            end
        endcase
        busy_nxt = (state_nxt == ST_IDLE) && (req == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            ptr       <= IDXW'(N - 1);
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            busy_none <= 1'b1;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            gnt       <= gnt_nxt;
            gnt_idx   <= idx_nxt;
            gnt_valid <= valid_nxt;
            busy_none <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_pe_arb_rr.sv
// Directed bench for pe_arb_rr at N=4: legacy priority, round-robin order,
// grant hold, mode switch, mid-grant reset and spurious ack.
module tb_pe_arb_rr;

    localparam int N    = 4;
    localparam int IDXW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic            mode;
    logic            ack;
    logic [N-1:0]    gnt;
    logic [IDXW-1:0] gnt_idx;
    logic            gnt_valid;
    logic            busy_none;

    int checks = 0;
    int errors = 0;
    logic [IDXW-1:0] exp_q[$];

    always #5 clk = ~clk;

    pe_arb_rr #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .mode      (mode),
        .ack       (ack),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .busy_none (busy_none)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one edge and settle; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = '0;
        ack  = 1'b0;
        mode = 1'b0;
        tick();
        rst  = 1'b0;
    endtask

    task automatic check_grant(input string tag, input logic [N-1:0] eg, input logic [IDXW-1:0] ei);
        check({tag, "_gnt"}, gnt, eg);
        check({tag, "_idx"}, gnt_idx, ei);
        check({tag, "_vld"}, gnt_valid, 1'b1);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_gnt"}, gnt, 4'b0000);
        check({tag, "_vld"}, gnt_valid, 1'b0);
        check({tag, "_busy"}, busy_none, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [IDXW-1:0] e;

        // Reset state
        do_reset();
        check("rst_gnt", gnt, 4'b0000);
        check("rst_idx", gnt_idx, 2'd0);
        check("rst_vld", gnt_valid, 1'b0);
        check("rst_busy", busy_none, 1'b1);
        check("rst_ptr", dut.ptr, 2'd3);

        // 1: legacy fixed priority
        mode = 1'b0; req = 4'b0110; ack = 1'b0;
        tick();
        check_grant("t1a", 4'b0100, 2'd2);
        check("t1a_busy", busy_none, 1'b0);
        ack = 1'b1; req = 4'b1010;
        tick();
        check_grant("t1b", 4'b1000, 2'd3);
        req = 4'b0010;
        tick();
        check_grant("t1c", 4'b0010, 2'd1);
        req = 4'b0001;
        tick();
        check_grant("t1d", 4'b0001, 2'd0);
        req = 4'b0000;
        tick();
        check_idle("t1e");

        // 2: round-robin order with continuous ack
        do_reset();
        mode = 1'b1; req = 4'b1111; ack = 1'b0;
        exp_q = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2};
        tick();
        e = exp_q.pop_front();
        check("t2_idx0", gnt_idx, e);
        check("t2_vld0", gnt_valid, 1'b1);
        ack = 1'b1;
        while (exp_q.size() > 0) begin
            tick();
            e = exp_q.pop_front();
            check("t2_idx", gnt_idx, e);
            check("t2_gnt", gnt, 4'b0001 << e);
            check("t2_vld", gnt_valid, 1'b1);
        end
        req = 4'b0000;
        tick();
        check_idle("t2_end");

        // 3: grant held across req change until ack
        do_reset();
        mode = 1'b1; req = 4'b0101; ack = 1'b0;
        tick();
        check_grant("t3a", 4'b0100, 2'd2);
        req = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_grant("t3_hold", 4'b0100, 2'd2);
        end
        ack = 1'b1;
        tick();
        check_grant("t3b", 4'b0001, 2'd0);
        req = 4'b0000;
        tick();
        check_idle("t3_end");

        // 4: fixed starves bit 0; round-robin after mid-grant switch alternates
        do_reset();
        mode = 1'b0; req = 4'b1001; ack = 1'b0;
        tick();
        check_grant("t4a", 4'b1000, 2'd3);
        ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_grant("t4_fix", 4'b1000, 2'd3);
        end
        ack = 1'b0; mode = 1'b1;
        tick();
        check_grant("t4_sw", 4'b1000, 2'd3);
        ack = 1'b1;
        tick();
        check_grant("t4_rr0", 4'b0001, 2'd0);
        tick();
        check_grant("t4_rr1", 4'b1000, 2'd3);
        tick();
        check_grant("t4_rr2", 4'b0001, 2'd0);

        // 5: reset while granted
        do_reset();
        mode = 1'b1; req = 4'b1111; ack = 1'b0;
        tick();
        ack = 1'b1;
        tick();
        tick();
        check_grant("t5_pre", 4'b0010, 2'd1);
        rst = 1'b1;
        tick();
        check("t5_gnt", gnt, 4'b0000);
        check("t5_idx", gnt_idx, 2'd0);
        check("t5_vld", gnt_valid, 1'b0);
        check("t5_busy", busy_none, 1'b1);
        check("t5_ptr", dut.ptr, 2'd3);
        rst = 1'b0; ack = 1'b0;
        tick();
        check_grant("t5_post", 4'b1000, 2'd3);

        // 6: spurious ack while idle
        ack = 1'b1; req = 4'b0000;
        tick();
        check_idle("t6_drop");
        for (int i = 0; i < 3; i++) begin
            tick();
            check_idle("t6_spur");
            check("t6_idx", gnt_idx, 2'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
